signed_seq_divider: RTL and testbench
=====================================

Name: signed_seq_divider

Overview:
Sequential signed integer divider. It is the inverse operation of the Booth multiplier datapath, and it reuses the same add/subtract-per-cycle style: non-restoring division, one quotient bit per clock. It accepts a two's-complement dividend and divisor through a start/done handshake. It returns a quotient truncated toward zero and a remainder that carries the sign of the dividend. It sits beside the multiplier as the ALU's divide unit.

Parameters:
WIDTH, 16, operand/result width in bits (two's complement); must be >= 4

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  signed dividend, captured when start is accepted
divisor  input  WIDTH  signed divisor, captured when start is accepted
busy  output  1  high from the cycle after start is accepted through the DONE cycle
done  output  1  one-cycle pulse: results valid
quotient  output  WIDTH  signed quotient, held until the next accepted start
remainder  output  WIDTH  signed remainder, held until the next accepted start
div_by_zero  output  1  flag for the last operation, held with the results
overflow  output  1  flag for the last operation (MIN / -1), held with the results

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- FSM states: IDLE, LOAD, CALC, CORR, DONE.
  - IDLE: start=1 at an edge captures the operands and moves to LOAD.
  - LOAD (1 cycle): form magnitudes |dividend| and |divisor| in WIDTH+1 bits; record both signs; iteration counter=WIDTH-1.
  - CALC (WIDTH cycles): non-restoring step on a (WIDTH+1)-bit partial remainder P and a WIDTH-bit shift register.
    - Shift {P,Q} left by 1.
    - If P was >= 0, then P = P - |divisor|; otherwise P = P + |divisor|.
    - New Q LSB = ~P sign.
    - Counter decrements; on counter == 0 go to CORR.
  - CORR (1 cycle):
    - If P < 0, add |divisor| back into P.
    - Apply signs: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
    - Evaluate special cases (see below).
  - DONE (1 cycle): done=1, results and flags updated and visible; return to IDLE.
- Latency: done is high in the cycle WIDTH+3 clocks after the edge that accepted start (19 for WIDTH=16). Latency is fixed for all operand values, including the special cases.
- Throughput: a new start can be accepted in the first IDLE cycle after DONE.
- Handshake rules:
  - start while busy is ignored; it is not queued.
  - start held high continuously restarts an operation every WIDTH+4 cycles.
  - Input changes after acceptance have no effect.
- Width rules:
  - Internal magnitudes and the partial remainder are WIDTH+1 bits, so |MIN| = 2^(WIDTH-1) is representable.
  - Outputs are the low WIDTH bits.
- Special cases, resolved in CORR:
  - divisor == 0: div_by_zero=1, quotient = all ones (-1), remainder = dividend, overflow=0.
  - dividend == MIN and divisor == -1: overflow=1, quotient = MIN (wrapped), remainder = 0.
  - Otherwise both flags are 0.
  - dividend == 0: quotient=0, remainder=0.
- Outputs quotient, remainder and the flags change only in the DONE-entry update. They are stable at all other times except reset.

Test Plan:
1. 100 / 7 -> after 19 cycles done=1 for exactly 1 cycle; quotient=14, remainder=2, flags=0.
2. Sign combinations:
   - -100 / 7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2).
   - 100 / -7 -> quotient=0xFFF2, remainder=2.
   - -100 / -7 -> quotient=14, remainder=0xFFFE.
3. Boundary operands:
   - 0x8000 / 0xFFFF -> overflow=1, quotient=0x8000, remainder=0.
   - 0x8000 / 1 -> quotient=0x8000, remainder=0, overflow=0.
   - 0x7FFF / 0x7FFF -> quotient=1, remainder=0.
4. 5 / 0 -> div_by_zero=1, quotient=0xFFFF, remainder=5, latency still 19. Then 9 / 3 -> quotient=3, flags cleared.
5. Pulse start with new operands at cycles 3 and 10 of a busy operation -> ignored; results match the first operands only; busy stays high through DONE.
6. Assert rst at CALC cycle 8 -> next cycle: busy=0, done never pulses, outputs=0. A new start then completes normally in 19 cycles.

Source files
------------

// File: rtl/signed_seq_divider.sv
// rtl/signed_seq_divider.sv - non-restoring signed sequential divider, one quotient bit per clock
module signed_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, CALC, CORR, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [WIDTH:0]   p_q, p_d, m_q, m_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;

    logic [WIDTH:0]   p_shift, p_step, p_fix;
    logic [WIDTH-1:0] q_signed, r_signed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            p_q     <= '0;
            m_q     <= '0;
            qr_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            p_q     <= p_d;
            m_q     <= m_d;
            qr_q    <= qr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = CORR;
            CORR:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Magnitudes are WIDTH+1 bits wide so that |MIN| stays positive through the iteration.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        p_d     = p_q;
        m_d     = m_q;
        qr_d    = qr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        p_shift  = {p_q[WIDTH-1:0], qr_q[WIDTH-1]};
        p_step   = p_q[WIDTH] ? (p_shift + m_q) : (p_shift - m_q);
        p_fix    = p_q[WIDTH] ? (p_q + m_q) : p_q;
        q_signed = (neg_a_q ^ neg_b_q) ? -qr_q : qr_q;
        r_signed = neg_a_q ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = dividend;
                    b_d = divisor;
                end
            end
            LOAD: begin
                neg_a_d = a_q[WIDTH-1];
                neg_b_d = b_q[WIDTH-1];
                qr_d    = a_q[WIDTH-1] ? -a_q : a_q;
                m_d     = b_q[WIDTH-1] ? -{b_q[WIDTH-1], b_q} : {1'b0, b_q};
                p_d     = '0;
                cnt_d   = CNT_INIT;
            end
            CALC: begin
                p_d   = p_step;
                qr_d  = {qr_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q - 1'b1;
            end
            CORR: begin
                if (b_q == '0) begin
                    quot_d = '1;
                    rem_d  = a_q;
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                end else begin
                    // MIN / -1 wraps naturally to MIN; only the flag needs forcing.
                    quot_d = q_signed;
                    rem_d  = r_signed;
                    dbz_d  = 1'b0;
                    ovf_d  = (a_q == MIN_VAL) && (&b_q);
                end
            end
            default: ;
        endcase
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_signed_seq_divider.sv
// tb/tb_signed_seq_divider.sv - self-checking bench for signed_seq_divider against an arithmetic model
module tb_signed_seq_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend, divisor;
    logic        busy, done;
    logic [15:0] quotient, remainder;
    logic        div_by_zero, overflow;

    int tests = 0;
    int fails = 0;

    signed_seq_divider #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
        int ai, bi;
        ai = $signed(a);
        bi = $signed(b);
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            dz = 1'b1; q = 16'hFFFF; r = a;
        end else if (ai == -32768 && bi == -1) begin
            ov = 1'b1; q = 16'h8000; r = 16'h0000;
        end else begin
            q = 16'(ai / bi);
            r = 16'(ai % bi);
        end
    endfunction

    task automatic chk_results(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq, er;
        logic        edz, eov;
        model(a, b, eq, er, edz, eov);
        chk({tag, "/quot"}, {16'h0, quotient}, {16'h0, eq});
        chk({tag, "/rem"}, {16'h0, remainder}, {16'h0, er});
        chk({tag, "/flags"}, {30'h0, div_by_zero, overflow}, {30'h0, edz, eov});
    endtask

    // lat counts rising edges including the accepting one; inject pulses start mid-operation.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input bit inject);
        int lat;
        bit busy_ok;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_ok = busy;
        while (!done && lat < 40) begin
            if (inject && (lat == 2 || lat == 9)) begin
                start = 1'b1; dividend = 16'($urandom); divisor = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            busy_ok = busy_ok & busy;
        end
        start = 1'b0;
        chk({tag, "/lat"}, lat, 19);
        if (inject) chk({tag, "/busy_held"}, {31'h0, busy_ok}, 1);
        chk_results(tag, a, b);
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, {30'h0, done, busy}, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int n;
        bit seen;

        rst = 1'b1; start = 1'b0; dividend = 16'h0; divisor = 16'h0;
        @(posedge clk); #1;
        chk("reset/ctl", {30'h0, busy, done}, 0);
        chk("reset/data", {quotient, remainder}, 0);
        chk("reset/flags", {30'h0, div_by_zero, overflow}, 0);
        @(negedge clk); rst = 1'b0;

        do_op("100/7", 16'd100, 16'd7, 0);
        do_op("-100/7", 16'hFF9C, 16'd7, 0);
        do_op("100/-7", 16'd100, 16'hFFF9, 0);
        do_op("-100/-7", 16'hFF9C, 16'hFFF9, 0);
        do_op("min/-1", 16'h8000, 16'hFFFF, 0);
        do_op("min/1", 16'h8000, 16'h0001, 0);
        do_op("max/max", 16'h7FFF, 16'h7FFF, 0);
        do_op("5/0", 16'd5, 16'd0, 0);
        do_op("9/3", 16'd9, 16'd3, 0);
        do_op("0/-9", 16'd0, 16'hFFF7, 0);
        do_op("ignored_start", 16'd1000, 16'hFFFD, 1);

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case (i % 6)
                1: rb = 16'($urandom_range(0, 15)) - 16'd8;
                2: ra = 16'h8000;
                3: rb = 16'h0000;
                default: ;
            endcase
            do_op("random", ra, rb, 0);
        end

        // Held start: operations repeat back to back.
        @(negedge clk);
        dividend = 16'hC350; divisor = 16'd123; start = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 40);
        chk("held/first_done", {31'h0, done}, 1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 40);
        start = 1'b0;
        chk("held/period", n, 20);
        chk_results("held", 16'hC350, 16'd123);

        // Reset in CALC cycle 8 aborts the operation.
        @(negedge clk);
        dividend = 16'd1234; divisor = 16'hFFC8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort/ctl", {30'h0, busy, done}, 0);
        chk("abort/data", {quotient, remainder}, 0);
        chk("abort/flags", {30'h0, div_by_zero, overflow}, 0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin @(posedge clk); #1; seen |= done; end
        chk("abort/no_done", {31'h0, seen}, 0);
        do_op("after_abort", 16'd30000, 16'hFF85, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
